// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;

   // A depth of 2 still needs one address bit.
   function automatic int addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-writeback bits with set/clear/query ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int NUM_CLR = 2,
   parameter int NUM_Q   = 2,
   localparam int AW     = addr_w(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        set_en_i,
   input  logic [AW-1:0]               set_addr_i,
   input  logic [NUM_CLR-1:0]          clr_en_i,
   input  logic [NUM_CLR-1:0][AW-1:0]  clr_addr_i,
   input  logic [NUM_Q-1:0][AW-1:0]    q_addr_i,
   output logic [NUM_Q-1:0]            q_busy_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Set is applied after clears so an issue wins over a same-cycle write.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_CLR; i++) begin
         if (clr_en_i[i] && (clr_addr_i[i] != '0))
            busy_d[clr_addr_i[i]] = 1'b0;
      end
      if (set_en_i && (set_addr_i != '0))
         busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   for (genvar j = 0; j < NUM_Q; j++) begin : g_q
      assign q_busy_o[j] = busy_q[q_addr_i[j]];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write arbitration, bypass and busy tracking.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 2,
   parameter int BYPASS  = 1,
   localparam int AW     = addr_w(DEPTH)
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic [NUM_WR-1:0]                WrEn,
   input  logic [NUM_WR-1:0][AW-1:0]        WrAddr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]    WrData,
   input  logic [NUM_RD-1:0][AW-1:0]        RdAddr,
   output logic [NUM_RD-1:0][DATA_W-1:0]    RdData,
   output logic [NUM_RD-1:0]                RdBusy,
   input  logic                             IssueEn,
   input  logic [AW-1:0]                    IssueAddr,
   output logic                             WrConflict
);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [NUM_WR-1:0] wr_vld;
   logic              conflict_q;
   logic              conflict_d;
   logic [NUM_RD-1:0] sb_busy;

   for (genvar i = 0; i < NUM_WR; i++) begin : g_wv
      assign wr_vld[i] = WrEn[i] && (WrAddr[i] != '0);
   end

   // Ascending loop lets the highest-index port overwrite earlier ones.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_vld[i])
            regs_d[WrAddr[i]] = WrData[i];
      end
      regs_d[0] = '0;
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int k = i + 1; k < NUM_WR; k++) begin
            if (wr_vld[i] && wr_vld[k] && (WrAddr[i] == WrAddr[k]))
               conflict_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         regs_q     <= '{default: '0};
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         conflict_q <= conflict_d;
      end
   end

   assign WrConflict = conflict_q;

   regfile_scoreboard #(
      .DEPTH   (DEPTH),
      .NUM_CLR (NUM_WR),
      .NUM_Q   (NUM_RD)
   ) u_sb (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .set_en_i   (IssueEn),
      .set_addr_i (IssueAddr),
      .clr_en_i   (WrEn),
      .clr_addr_i (WrAddr),
      .q_addr_i   (RdAddr),
      .q_busy_o   (sb_busy)
   );

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic              fwd_hit;
      logic [DATA_W-1:0] fwd_data;
      logic              iss_hit;

      always_comb begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_vld[i] && (WrAddr[i] == RdAddr[j])) begin
               fwd_hit  = 1'b1;
               fwd_data = WrData[i];
            end
         end
      end

      assign iss_hit = IssueEn && (IssueAddr == RdAddr[j]);

      // Reset gating keeps outputs at zero for the whole reset window.
      assign RdData[j] = Reset ? '0 :
                         ((BYPASS != 0) && fwd_hit) ? fwd_data :
                         regs_q[RdAddr[j]];

      assign RdBusy[j] = Reset ? 1'b0 :
                         ((BYPASS != 0) && fwd_hit && !iss_hit) ? 1'b0 :
                         sb_busy[j];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: bypass and non-bypass instances against a reference model.
module tb_regfile_mp;

   logic             Clock = 1'b0;
   logic             rst;
   logic [1:0]       we;
   logic [1:0][4:0]  wa;
   logic [1:0][31:0] wd;
   logic [1:0][4:0]  ra;
   logic             ie;
   logic [4:0]       ia;

   logic [1:0][31:0] rd_b, rd_n;
   logic [1:0]       bz_b, bz_n;
   logic             cf_b, cf_n;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   always #5 Clock = ~Clock;

   regfile_mp #(.BYPASS(1)) u_byp (
      .Clock(Clock), .Reset(rst),
      .WrEn(we), .WrAddr(wa), .WrData(wd),
      .RdAddr(ra), .RdData(rd_b), .RdBusy(bz_b),
      .IssueEn(ie), .IssueAddr(ia), .WrConflict(cf_b)
   );

   regfile_mp #(.BYPASS(0)) u_nob (
      .Clock(Clock), .Reset(rst),
      .WrEn(we), .WrAddr(wa), .WrData(wd),
      .RdAddr(ra), .RdData(rd_n), .RdBusy(bz_n),
      .IssueEn(ie), .IssueAddr(ia), .WrConflict(cf_n)
   );

   typedef struct {
      int          kind;
      int          inst;
      int          port;
      logic [31:0] exp;
   } item_t;

   item_t exp_q[$];

   bit [31:0] mem [32];
   bit        bsy [32];
   bit        conf;

   function automatic bit wr_hit(int a);
      for (int i = 0; i < 2; i++)
         if (we[i] && wa[i] == a && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_rd(int a, bit byp);
      logic [31:0] r;
      if (rst || a == 0) return 32'h0;
      r = mem[a];
      if (byp)
         for (int i = 0; i < 2; i++)
            if (we[i] && wa[i] == a) r = wd[i];
      return r;
   endfunction

   function automatic logic exp_busy(int a, bit byp);
      if (rst) return 1'b0;
      if (byp && wr_hit(a) && !(ie && ia == a)) return 1'b0;
      return bsy[a];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin
         mem[k] = '0;
         bsy[k] = 1'b0;
      end
      conf = 1'b0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_clear();
         return;
      end
      conf = we[0] && we[1] && wa[0] == wa[1] && wa[0] != 0;
      for (int i = 0; i < 2; i++)
         if (we[i] && wa[i] != 0) begin
            mem[wa[i]] = wd[i];
            bsy[wa[i]] = 1'b0;
         end
      if (ie && ia != 0) bsy[ia] = 1'b1;
   endtask

   function automatic logic [31:0] actual(item_t e);
      case (e.kind)
         0:       return (e.inst == 0) ? rd_b[e.port] : rd_n[e.port];
         1:       return {31'h0, (e.inst == 0) ? bz_b[e.port] : bz_n[e.port]};
         default: return {31'h0, (e.inst == 0) ? cf_b : cf_n};
      endcase
   endfunction

   initial begin : monitor
      item_t       e;
      logic [31:0] act;
      string       nm;
      forever begin
         @(negedge Clock);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e);
            checks++;
            if (act !== e.exp) begin
               errors++;
               nm = (e.kind == 0) ? "rddata" : (e.kind == 1) ? "rdbusy" : "conflict";
               $display("FAIL %s inst%0d port%0d ra=%0d t=%0t got %h want %h",
                        nm, e.inst, e.port, ra[e.port], $time, act, e.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout: driver did not finish t=%0t", $time);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic idle();
      we = '0; wa = '0; wd = '0; ie = 1'b0; ia = '0;
   endtask

   task automatic step();
      if (rst) model_clear();
      for (int n = 0; n < 2; n++) begin
         for (int p = 0; p < 2; p++) begin
            exp_q.push_back('{0, n, p, exp_rd(ra[p], n == 0)});
            exp_q.push_back('{1, n, p, {31'h0, exp_busy(ra[p], n == 0)}});
         end
         exp_q.push_back('{2, n, 0, {31'h0, conf}});
      end
      @(negedge Clock);
      @(posedge Clock);
      model_edge();
      #2;
   endtask

   initial begin : driver
      model_clear();
      rst = 1'b1; idle(); ra = '0;
      step(); step();
      rst = 1'b0;

      idle(); we = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[1] = 5; step();
      idle(); ra[0] = 0; ra[1] = 5; step();

      idle(); we = 2'b01; wa[0] = 7; wd[0] = 32'h12345678; ra[0] = 7; step();
      idle(); ra[0] = 7; step();

      idle(); we = 2'b11; wa[0] = 3; wa[1] = 3;
      wd[0] = 32'h1111; wd[1] = 32'h2222; ra[0] = 3; step();
      idle(); ra[0] = 3; step();
      idle(); step();

      idle(); ie = 1'b1; ia = 9; ra[0] = 9; step();
      for (int c = 0; c < 3; c++) begin idle(); ra[0] = 9; step(); end
      idle(); we = 2'b10; wa[1] = 9; wd[1] = 32'h55; ra[0] = 9; step();
      idle(); ra[0] = 9; step();

      idle(); we = 2'b01; wa[0] = 0; wd[0] = 32'hFFFFFFFF;
      ie = 1'b1; ia = 0; ra[0] = 0; step();
      idle(); ra[0] = 0; step();
      idle(); we = 2'b01; wa[0] = 4; wd[0] = 32'hA5A5_0004;
      ie = 1'b1; ia = 4; ra[0] = 4; step();
      idle(); ra[0] = 4; step();

      for (int r = 1; r < 32; r += 2) begin
         idle(); we = 2'b11;
         wa[0] = 5'(r); wd[0] = 32'hC000_0000 + r;
         wa[1] = 5'((r + 1) % 32); wd[1] = 32'hC000_0000 + r + 1;
         ie = 1'b1; ia = 5'(r + 1);
         ra[0] = 5'(r); ra[1] = 5'(r + 1);
         step();
      end
      idle(); ie = 1'b1; ia = 12; ra[0] = 12; ra[1] = 31; step();
      idle(); ra[0] = 12; ra[1] = 31;
      rst = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (rd_b[p] !== 32'h0 || rd_n[p] !== 32'h0 ||
             bz_b[p] !== 1'b0 || bz_n[p] !== 1'b0 ||
             cf_b !== 1'b0 || cf_n !== 1'b0) begin
            errors++;
            $display("FAIL async reset port%0d t=%0t rd %h/%h bz %b/%b cf %b/%b",
                     p, $time, rd_b[p], rd_n[p], bz_b[p], bz_n[p], cf_b, cf_n);
         end
      end
      step();
      we = 2'b11; wa[0] = 12; wa[1] = 31; wd = '1; ie = 1'b1; ia = 12; step();
      rst = 1'b0; idle(); ra[0] = 12; ra[1] = 31; step();

      for (int c = 0; c < 400; c++) begin
         idle();
         rst = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < 2; i++) begin
            we[i] = $urandom_range(0, 2) != 0;
            wa[i] = 5'($urandom_range(0, 7));
            wd[i] = $urandom;
            ra[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         end
         ie = $urandom_range(0, 2) == 0;
         ia = 5'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0; idle(); step();

      @(negedge Clock);
      #1;
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
